// File: rtl/keypad_debounce.sv
// keypad_debounce: conditions a raw 4x5 keypad for the calculator core.
// Synchronises the 20 key lines, debounces press and release, rejects chords,
// and emits one single-cycle pulse per accepted press.
// Ports:
//   sys_clk, rst         clock (rising edge), async active-high reset
//   raw_row1..raw_row4   raw key rows, 1 = pressed
//   key_row1..key_row4   one-cycle press pulse, same layout as the raw rows
//   key_valid            one-cycle pulse, coincident with the key_row pulse
//   key_code             index of the last accepted key, (row-1)*5 + col
//   multi_key            high while more than one synced key is pressed
//   busy                 high whenever the FSM is not idle
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [4:0] raw_row1,
  input  logic [4:0] raw_row2,
  input  logic [4:0] raw_row3,
  input  logic [4:0] raw_row4,
  output logic [4:0] key_row1,
  output logic [4:0] key_row2,
  output logic [4:0] key_row3,
  output logic [4:0] key_row4,
  output logic       key_valid,
  output logic [4:0] key_code,
  output logic       multi_key,
  output logic       busy
);

  localparam int unsigned NKEYS = 20;
  localparam int unsigned IDX_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    REL       = 2'd3
  } state_e;

  state_e             state_q;
  logic [NKEYS-1:0]   raw_flat;
  logic [NKEYS-1:0]   sync1_q;
  logic [NKEYS-1:0]   ks_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NKEYS-1:0]   kr_q;
  logic               valid_q;
  logic [IDX_W-1:0]   code_q;
  logic               multi_q;
  logic               busy_q;

  logic               ks_multi;
  logic               ks_one;
  logic               ks_zero;
  logic [IDX_W-1:0]   ks_idx;
  logic [NKEYS-1:0]   idx_onehot;

  // Flat key vector: bit (row-1)*5 + col
  assign raw_flat = {raw_row4, raw_row3, raw_row2, raw_row1};

  // Key-set classification; x & (x-1) clears the lowest set bit,
  // so a nonzero remainder means at least two keys are down.
  always_comb begin
    ks_zero    = (ks_q == '0);
    ks_multi   = ((ks_q & (ks_q - NKEYS'(1))) != '0);
    ks_one     = !ks_zero && !ks_multi;
    idx_onehot = NKEYS'(1) << idx_q;
    ks_idx     = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (ks_q[i]) ks_idx = IDX_W'(i);
    end
  end

  // Synchroniser, debounce FSM and registered outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= '0;
      ks_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      kr_q    <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= raw_flat;
      ks_q    <= sync1_q;
      multi_q <= ks_multi;
      kr_q    <= '0;
      valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (ks_one) begin
            idx_q   <= ks_idx;
            cnt_q   <= '0;
            state_q <= DEB_PRESS;
            busy_q  <= 1'b1;
          end
        end

        DEB_PRESS: begin
          busy_q <= 1'b1;
          if (ks_q == idx_onehot) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= HELD;
              code_q  <= idx_q;
              valid_q <= 1'b1;
              kr_q    <= idx_onehot;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // Bounce, release or chord during the press window: abort silently
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        HELD: begin
          busy_q <= 1'b1;
          if (ks_zero) begin
            cnt_q   <= '0;
            state_q <= REL;
          end
        end

        REL: begin
          busy_q <= 1'b1;
          if (ks_zero) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // Release bounce: back to held, no new pulse
            state_q <= HELD;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign key_row1  = kr_q[4:0];
  assign key_row2  = kr_q[9:5];
  assign key_row3  = kr_q[14:10];
  assign key_row4  = kr_q[19:15];
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign multi_key = multi_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with DEBOUNCE_CYCLES = 4.
module tb_keypad_debounce;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [19:0] raw = '0;
  logic [4:0] key_row1, key_row2, key_row3, key_row4;
  logic       key_valid;
  logic [4:0] key_code;
  logic       multi_key;
  logic       busy;
  logic [19:0] kr;

  int checks = 0;
  int errors = 0;

  keypad_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .raw_row1 (raw[4:0]),
    .raw_row2 (raw[9:5]),
    .raw_row3 (raw[14:10]),
    .raw_row4 (raw[19:15]),
    .key_row1 (key_row1),
    .key_row2 (key_row2),
    .key_row3 (key_row3),
    .key_row4 (key_row4),
    .key_valid(key_valid),
    .key_code (key_code),
    .multi_key(multi_key),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  assign kr = {key_row4, key_row3, key_row2, key_row1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Press a single key held steady; pulse expected only after edge 7
  task automatic press_check(input string tag, input int code);
    logic [19:0] oh;
    oh = 20'd1 << code;
    raw = oh;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk({tag, "_valid"}, 32'(key_valid), 32'(e == 7));
      chk({tag, "_rows"}, 32'(kr), (e == 7) ? 32'(oh) : 32'd0);
      if (e == 3) chk({tag, "_busy3"}, 32'(busy), 32'd1);
      if (e == 2) chk({tag, "_busy2"}, 32'(busy), 32'd0);
    end
    chk({tag, "_code"}, 32'(key_code), 32'(code));
  endtask

  // Release and confirm return to idle at edge 7 after release
  task automatic release_check(input string tag);
    raw = '0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk({tag, "_relvalid"}, 32'(key_valid), 32'd0);
      if (e == 6) chk({tag, "_busy6"}, 32'(busy), 32'd1);
      if (e == 7) chk({tag, "_busy7"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int pulses;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_rows", 32'(kr), 32'd0);
    chk("rst_multi", 32'(multi_key), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // 1: row3 col1 -> code 11
    press_check("t1", 11);
    chk("t1_row3", 32'(key_row3), 32'd0);
    release_check("t1");

    // 2: row1 col0 bounces 1,0,1,0 on edges 1-4, stable from edge 5, pulse at edge 11
    pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      raw = (e <= 4) ? ((e % 2 == 1) ? 20'd1 : 20'd0) : 20'd1;
      tick();
      chk("t2_valid", 32'(key_valid), 32'(e == 11));
      if (key_valid) pulses++;
    end
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_code", 32'(key_code), 32'd0);
    release_check("t2");

    // 3: chord row4 col4 (19) + row2 col3 (8) for 20 cycles
    raw = (20'd1 << 19) | (20'd1 << 8);
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (key_valid) pulses++;
      if (e == 2) chk("t3_multi2", 32'(multi_key), 32'd0);
      if (e == 3) chk("t3_multi3", 32'(multi_key), 32'd1);
      if (e == 20) chk("t3_multi20", 32'(multi_key), 32'd1);
      if (e == 20) chk("t3_busy", 32'(busy), 32'd0);
    end
    chk("t3_pulses", 32'(pulses), 32'd0);
    chk("t3_code", 32'(key_code), 32'd0);
    raw = '0;
    tick(); tick(); tick();
    chk("t3_multi_off", 32'(multi_key), 32'd0);

    // 4: key 7 press, release with bounces 0,1,0,1 (2 cycles each), then 0
    pulses = 0;
    raw = 20'd1 << 7;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (key_valid) pulses++;
    end
    chk("t4_code", 32'(key_code), 32'd7);
    for (int e = 0; e < 8; e++) begin
      raw = ((e / 2) % 2 == 1) ? (20'd1 << 7) : 20'd0;
      tick();
      if (key_valid) pulses++;
      chk("t4_bounce_busy", 32'(busy), 32'd1);
    end
    raw = '0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (key_valid) pulses++;
      if (e == 6) chk("t4_busy6", 32'(busy), 32'd1);
      if (e == 7) chk("t4_busy7", 32'(busy), 32'd0);
    end
    chk("t4_pulses", 32'(pulses), 32'd1);

    // 5: reset mid DEB_PRESS (cnt=2 after edge 5), key kept held
    raw = 20'd1 << 2;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("t5_pre_valid", 32'(key_valid), 32'd0);
    end
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_code", 32'(key_code), 32'd0);
    chk("t5_rst_valid", 32'(key_valid), 32'd0);
    tick();
    tick();
    chk("t5_rst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    press_check("t5", 2);
    release_check("t5");

    // 6: key 3 then key 19, each fully released
    press_check("t6a", 3);
    release_check("t6a");
    press_check("t6b", 19);
    chk("t6b_row4", 32'(key_row4), 32'd0);
    release_check("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
